load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_load_align.sv | 27 ++
 rtl/load_store_unit.sv | 118 +++++++++++
 tb/tb_load_store_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - opcode constants, FSM state type and access-check helpers for the load/store unit
`timescale 1ns/1ps
package lsu_pkg;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} lsu_state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Undefined opcodes, misalignment and out-of-range word index all fold into one error bit.
  function automatic logic access_err(input logic [3:0] op, input logic [31:0] addr,
                                      input logic [31:0] words);
    logic half_bad;
    logic word_bad;
    half_bad = ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && addr[0];
    word_bad = ((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00);
    return !(is_load(op) || is_store(op)) || half_bad || word_bad ||
           ({2'b00, addr[31:2]} >= words);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - little-endian lane select and sign/zero extension of a loaded word
`timescale 1ns/1ps
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{byte_off, 3'b000} +: 8];
    lane_h = byte_off[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  data = {24'h0, lane_b};
      OP_LH:   data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  data = {16'h0, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with read-modify-write for sub-word stores
`timescale 1ns/1ps
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic        err_q;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_ready = (state == IDLE) && !rst;
  assign req_err   = access_err(req_op, req_addr, 32'(ADDR_WORDS));

  lsu_load_align u_load_align (
    .op       (op_q),
    .byte_off (off_q),
    .word     (mem_rdata),
    .data     (load_data)
  );

  // Old word with the addressed byte or halfword lane overwritten.
  always_comb begin
    merged = mem_rdata;
    if (op_q == OP_SB)
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= 4'h0;
      off_q      <= 2'b00;
      wdata_q    <= 16'h0;
      err_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            off_q     <= req_addr[1:0];
            wdata_q   <= req_wdata[15:0];
            err_q     <= req_err;
            mem_addr  <= {2'b00, req_addr[31:2]};
            // Full-word stores write during ACCESS; sub-word stores wait for MERGE.
            mem_we    <= (req_op == OP_SW) && !req_err;
            mem_wdata <= ((req_op == OP_SW) && !req_err) ? req_wdata : 32'h0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!err_q && ((op_q == OP_SB) || (op_q == OP_SH))) begin
            mem_we    <= 1'b1;
            mem_wdata <= merged;
            state     <= MERGE;
          end else begin
            mem_we     <= 1'b0;
            mem_wdata  <= 32'h0;
            mem_addr   <= 32'h0;
            resp_valid <= 1'b1;
            resp_err   <= err_q;
            resp_rdata <= (!err_q && is_load(op_q)) ? load_data : 32'h0;
            state      <= RESP;
          end
        end
        MERGE: begin
          mem_we     <= 1'b0;
          mem_wdata  <= 32'h0;
          mem_addr   <= 32'h0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized checks of load_store_unit against a word-array reference model
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LBU = 4'd4, LHU = 4'd5;
  localparam logic [3:0] SB = 4'd8, SH = 4'd9, SW = 4'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'h0;

  always @(posedge clk)
    if (mem_we && (mem_addr < 32'd1024)) mem[mem_addr[9:0]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: access size from the opcode, then shifts and masks on the word array.
  task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata, output logic [31:0] word,
                       output int lat, output int we_cyc);
    int size;
    bit ld, st, sgn;
    logic [31:0] old, mask;
    int sh;
    size = 0; ld = 0; st = 0; sgn = 0;
    case (op)
      LB:  begin size = 1; ld = 1; sgn = 1; end
      LBU: begin size = 1; ld = 1; end
      LH:  begin size = 2; ld = 1; sgn = 1; end
      LHU: begin size = 2; ld = 1; end
      LW:  begin size = 4; ld = 1; end
      SB:  begin size = 1; st = 1; end
      SH:  begin size = 2; st = 1; end
      SW:  begin size = 4; st = 1; end
      default: size = 0;
    endcase
    if (size == 0) err = 1;
    else err = ((addr % size) != 0) || ((addr / 4) >= 1024);
    rdata = 0; word = 0; we_cyc = 0; lat = 2;
    if (!err) begin
      old  = ref_mem[addr[11:2]];
      sh   = (addr % 4) * 8;
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
      if (ld) begin
        rdata = (old >> sh) & mask;
        if (sgn && rdata[8 * size - 1]) rdata = rdata | ~mask;
      end
      if (st) begin
        word   = (old & ~(mask << sh)) | ((wdata & mask) << sh);
        lat    = (size == 4) ? 2 : 3;
        we_cyc = (size == 4) ? 1 : 2;
      end
    end
  endtask

  task automatic run_req(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata);
    logic        exp_err, got_err;
    logic [31:0] exp_rdata, exp_word, got_rdata, we_addr, we_data;
    int          exp_lat, exp_we_cyc, lat, we_n, we_cyc;
    model(op, addr, wdata, exp_err, exp_rdata, exp_word, exp_lat, exp_we_cyc);
    lat = 0; we_n = 0; we_cyc = 0; we_addr = 0; we_data = 0; got_rdata = 0; got_err = 0;
    @(negedge clk);
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    chk({tag, ":ready"}, {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0; req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_we) begin we_n++; we_cyc = k; we_addr = mem_addr; we_data = mem_wdata; end
      if (resp_valid) begin lat = k; got_rdata = resp_rdata; got_err = resp_err; end
    end
    chk({tag, ":latency"}, lat, exp_lat);
    chk({tag, ":err"}, {31'h0, got_err}, {31'h0, exp_err});
    chk({tag, ":rdata"}, got_rdata, exp_rdata);
    chk({tag, ":we_count"}, we_n, (exp_we_cyc != 0) ? 1 : 0);
    if (exp_we_cyc != 0) begin
      chk({tag, ":we_cycle"}, we_cyc, exp_we_cyc);
      chk({tag, ":we_addr"}, we_addr, addr >> 2);
      chk({tag, ":we_data"}, we_data, exp_word);
      ref_mem[addr[11:2]] = exp_word;
    end
    @(negedge clk);
    chk({tag, ":one_pulse"}, {31'h0, resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [11];
    int quiet_we, quiet_rv;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 4'd3, 4'd7, 4'd14};
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[32] = 32'h0000_0005; ref_mem[32] = 32'h0000_0005;
    mem[33] = 32'h0000_0006; ref_mem[33] = 32'h0000_0006;

    #12;
    chk("rst:ready", {31'h0, req_ready}, 32'd0);
    chk("rst:resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst:resp_rdata", resp_rdata, 32'd0);
    chk("rst:resp_err", {31'h0, resp_err}, 32'd0);
    chk("rst:mem_we", {31'h0, mem_we}, 32'd0);
    chk("rst:mem_addr", mem_addr, 32'd0);
    chk("rst:mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_req("lw80", LW, 32'h80, 32'h0);
    chk("lw80:value", ref_mem[32], 32'h0000_0005);
    run_req("sw84", SW, 32'h84, 32'hDEAD_BEEF);
    run_req("lb87", LB, 32'h87, 32'h0);
    run_req("lbu87", LBU, 32'h87, 32'h0);
    run_req("sb81", SB, 32'h81, 32'h0000_00AA);
    chk("sb81:word", mem[32], 32'h0000_AA05);
    run_req("lh82", LH, 32'h82, 32'h0);
    run_req("lh83", LH, 32'h83, 32'h0);
    run_req("sw1002", SW, 32'h1002, 32'h1234_5678);
    run_req("lw1000", LW, 32'h1000, 32'h0);
    run_req("lhu86", LHU, 32'h86, 32'h0);
    run_req("undef", 4'd3, 32'h80, 32'h0);

    // Abort an SH during its MERGE write cycle.
    @(negedge clk);
    req_op = SH; req_addr = 32'h80; req_wdata = 32'h0000_1234; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort:merge_we", {31'h0, mem_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort:we_cleared", {31'h0, mem_we}, 32'd0);
    chk("abort:ready_low", {31'h0, req_ready}, 32'd0);
    quiet_we = 0; quiet_rv = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      quiet_we += mem_we; quiet_rv += resp_valid;
    end
    rst = 1'b0;
    #1;
    chk("abort:ready_after", {31'h0, req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      quiet_we += mem_we; quiet_rv += resp_valid;
    end
    chk("abort:no_we", quiet_we, 0);
    chk("abort:no_resp", quiet_rv, 0);
    chk("abort:word", mem[32], ref_mem[32]);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? $urandom : {$urandom_range(0, 1100), 2'b00} | $urandom_range(0, 3);
      run_req("rand", ops[$urandom_range(0, 10)], a, $urandom);
    end

    quiet_we = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) quiet_we++;
    chk("final:mem_mismatches", quiet_we, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
